// File: rtl/wb_arb_pkg.sv
// Shared encodings for the Wishbone RAM arbiter.
// State encoding, Wishbone cycle-type constants and the timeout counter width.
package wb_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int CNT_W = 8;

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Combinational round-robin picker.
// The search starts one index after the last owner and wraps around.
module wb_arb_rr_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt
);

    // Walk from the farthest offset down so the nearest requester wins.
    always_comb begin
        gnt = '0;
        for (int i = N; i >= 1; i--) begin
            logic [IW-1:0] idx;
            idx = IW'((int'(last) + i) % N);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_ram_arbiter.sv
// Round-robin Wishbone arbiter sharing one RAM slave among several masters.
// Define WB_ARB_TIMEOUT_EN to abort transfers that a slave stalls for too long.
module wb_ram_arbiter #(
    parameter int NUM_MASTERS    = 3,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_ni,
    input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [NUM_MASTERS-1:0]      m_cyc_i,
    input  logic [NUM_MASTERS-1:0]      m_stb_i,
    input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
    output logic [DW-1:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]      m_ack_o,
    output logic [NUM_MASTERS-1:0]      m_err_o,
    output logic [NUM_MASTERS-1:0]      m_rty_o,
    output logic [AW-1:0]               s_adr_o,
    output logic [DW-1:0]               s_dat_o,
    output logic [DW/8-1:0]             s_sel_o,
    output logic                        s_we_o,
    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    output logic [2:0]                  s_cti_o,
    output logic [1:0]                  s_bte_o,
    input  logic [DW-1:0]               s_dat_i,
    input  logic                        s_ack_i,
    input  logic                        s_err_i,
    input  logic                        s_rty_i,
    output logic [NUM_MASTERS-1:0]      grant_o
);

    import wb_arb_pkg::*;

    localparam int N  = NUM_MASTERS;
    localparam int SW = DW / 8;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    arb_state_t    state_q;
    logic [N-1:0]  grant_q;
    logic [IW-1:0] last_q;
    logic [N-1:0]  pick;
    logic [IW-1:0] pick_idx;
    logic          busy;
    logic          owner_cyc;
    logic          owner_stb;
    logic          timeout_hit;
    logic          term_en;

    assign busy    = (state_q == BUSY);
    assign grant_o = grant_q;
    assign m_dat_o = s_dat_i;

    wb_arb_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req  (m_cyc_i),
        .last (last_q),
        .gnt  (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (pick[k]) pick_idx = IW'(k);
        end
    end

    // Grant is one-hot (or zero), so an OR of masked slices is the mux.
    always_comb begin
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        s_we_o    = 1'b0;
        s_cti_o   = '0;
        s_bte_o   = '0;
        owner_cyc = 1'b0;
        owner_stb = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (grant_q[k]) begin
                s_adr_o   |= m_adr_i[k*AW +: AW];
                s_dat_o   |= m_dat_i[k*DW +: DW];
                s_sel_o   |= m_sel_i[k*SW +: SW];
                s_we_o    |= m_we_i[k];
                s_cti_o   |= m_cti_i[k*3 +: 3];
                s_bte_o   |= m_bte_i[k*2 +: 2];
                owner_cyc |= m_cyc_i[k];
                owner_stb |= m_stb_i[k];
            end
        end
    end

    assign s_cyc_o = busy && owner_cyc && !timeout_hit;
    assign s_stb_o = busy && owner_stb && !timeout_hit;

    assign term_en = wb_rst_ni && busy;
    assign m_ack_o = grant_q & {N{term_en && s_ack_i}};
    assign m_rty_o = grant_q & {N{term_en && s_rty_i}};
    assign m_err_o = grant_q & {N{term_en && (s_err_i || timeout_hit)}};

`ifdef WB_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] to_cnt_q;

    assign timeout_hit = busy && (to_cnt_q == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni || !s_stb_o || s_ack_i || s_err_i || s_rty_i) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + CNT_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(N - 1);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|m_cyc_i) begin
                        state_q <= BUSY;
                        grant_q <= pick;
                        last_q  <= pick_idx;
                    end
                end
                BUSY: begin
                    if (!owner_cyc || timeout_hit) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed bench for wb_ram_arbiter.
// Define WB_ARB_TIMEOUT_EN to exercise the stalled-slave abort path.
module tb_wb_ram_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat;
    logic [N*SW-1:0] m_sel;
    logic [N-1:0]    m_we;
    logic [N-1:0]    m_cyc;
    logic [N-1:0]    m_stb;
    logic [N*3-1:0]  m_cti;
    logic [N*2-1:0]  m_bte;
    logic [DW-1:0]   m_dat_o;
    logic [N-1:0]    m_ack;
    logic [N-1:0]    m_err;
    logic [N-1:0]    m_rty;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_dat_o;
    logic [SW-1:0]   s_sel;
    logic            s_we;
    logic            s_cyc;
    logic            s_stb;
    logic [2:0]      s_cti;
    logic [1:0]      s_bte;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack;
    logic            s_err;
    logic            s_rty;
    logic [N-1:0]    grant;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_ram_arbiter #(
        .NUM_MASTERS    (N),
        .AW             (AW),
        .DW             (DW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .m_adr_i   (m_adr),
        .m_dat_i   (m_dat),
        .m_sel_i   (m_sel),
        .m_we_i    (m_we),
        .m_cyc_i   (m_cyc),
        .m_stb_i   (m_stb),
        .m_cti_i   (m_cti),
        .m_bte_i   (m_bte),
        .m_dat_o   (m_dat_o),
        .m_ack_o   (m_ack),
        .m_err_o   (m_err),
        .m_rty_o   (m_rty),
        .s_adr_o   (s_adr),
        .s_dat_o   (s_dat_o),
        .s_sel_o   (s_sel),
        .s_we_o    (s_we),
        .s_cyc_o   (s_cyc),
        .s_stb_o   (s_stb),
        .s_cti_o   (s_cti),
        .s_bte_o   (s_bte),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack),
        .s_err_i   (s_err),
        .s_rty_i   (s_rty),
        .grant_o   (grant)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cyc(input logic [N-1:0] v);
        m_cyc = v;
        m_stb = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] rr_exp [4];
        int           rr_idx [4];
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
        rr_idx = '{0, 1, 2, 0};

        for (int k = 0; k < N; k++) begin
            m_adr[k*AW +: AW] = 32'h1000 * (k + 1);
            m_dat[k*DW +: DW] = 32'hA0 + k;
        end
        m_sel   = '1;
        m_we    = '0;
        m_cti   = '0;
        m_bte   = '0;
        set_cyc('0);
        s_dat_i = 32'hDEAD_BEEF;
        s_ack   = 1'b1;
        s_err   = 1'b0;
        s_rty   = 1'b0;

        // Reset state, with a stray slave ack that must not leak out.
        step();
        step();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_scyc", 32'(s_cyc), 0);
        chk("rst_ack", 32'(m_ack), 0);
        chk("dat_pass", m_dat_o, 32'hDEAD_BEEF);
        s_ack = 1'b0;
        rst_n = 1'b1;

        // All three request continuously; each drops after one ack.
        set_cyc(3'b111);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_grant", 32'(grant), 32'(rr_exp[i]));
            chk("rr_adr", s_adr, 32'h1000 * (rr_idx[i] + 1));
            s_ack = 1'b1;
            #1;
            chk("rr_ack", 32'(m_ack), 32'(rr_exp[i]));
            step();
            s_ack = 1'b0;
            set_cyc(m_cyc & ~rr_exp[i]);
            step();
            chk("rr_idle", 32'(grant), 0);
            chk("rr_scyc", 32'(s_cyc), 0);
            set_cyc(3'b111);
        end

        // Master 1 bursts while master 0 waits.
        set_cyc(3'b011);
        step();
        chk("bu_grant", 32'(grant), 32'b010);
        for (int b = 0; b < 4; b++) begin
            m_cti[3 +: 3]  = (b < 3) ? 3'b010 : 3'b111;
            m_adr[AW +: AW] = 32'h100 + 32'(4 * b);
            s_ack = 1'b1;
            #1;
            chk("bu_adr", s_adr, 32'h100 + 32'(4 * b));
            chk("bu_cti", 32'(s_cti), (b < 3) ? 32'h2 : 32'h7);
            chk("bu_ack", 32'(m_ack), 32'b010);
            step();
        end
        s_ack = 1'b0;
        m_cti = '0;
        set_cyc(3'b001);
        #1;
        chk("bu_m0_noack", 32'(m_ack), 0);
        step();
        chk("bu_idle", 32'(grant), 0);
        m_we[0]           = 1'b1;
        m_sel[0 +: SW]    = 4'h3;
        m_dat[0 +: DW]    = 32'h1234_5678;
        step();
        chk("bu_m0_grant", 32'(grant), 32'b001);
        chk("mx_we", 32'(s_we), 1);
        chk("mx_sel", 32'(s_sel), 32'h3);
        chk("mx_dat", s_dat_o, 32'h1234_5678);
        m_we = '0;
        set_cyc('0);
        step();
        step();

        // Slave error and retry on master 2.
        set_cyc(3'b100);
        step();
        chk("er_grant", 32'(grant), 32'b100);
        s_err = 1'b1;
        #1;
        chk("er_err", 32'(m_err), 32'b100);
        chk("er_ack", 32'(m_ack), 0);
        step();
        s_err = 1'b0;
        #1;
        chk("er_one", 32'(m_err), 0);
        s_rty = 1'b1;
        #1;
        chk("er_rty", 32'(m_rty), 32'b100);
        s_rty = 1'b0;
        set_cyc('0);
        step();
        step();

        // Slave never acks master 0.
        set_cyc(3'b001);
        step();
`ifdef WB_ARB_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            chk("to_quiet", 32'(m_err), 0);
            step();
        end
        chk("to_err", 32'(m_err), 32'b001);
        chk("to_scyc", 32'(s_cyc), 0);
        step();
        chk("to_idle", 32'(grant), 0);
`else
        for (int i = 0; i < 40; i++) step();
        chk("st_grant", 32'(grant), 32'b001);
        chk("st_err", 32'(m_err), 0);
        chk("st_scyc", 32'(s_cyc), 1);
`endif
        set_cyc('0);
        step();
        step();

        // Reset in the second beat of a master 1 burst.
        m_cti[3 +: 3] = 3'b010;
        set_cyc(3'b010);
        step();
        chk("rs_grant", 32'(grant), 32'b010);
        s_ack = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        chk("rs_ack", 32'(m_ack), 0);
        step();
        chk("rs_scyc", 32'(s_cyc), 0);
        chk("rs_gclr", 32'(grant), 0);
        rst_n = 1'b1;
        s_ack = 1'b0;
        m_cti = '0;
        set_cyc(3'b100);
        step();
        chk("rs_m2", 32'(grant), 32'b100);
        set_cyc('0);
        step();

        // Lone requester toggling cyc is re-granted every time.
        for (int i = 0; i < 3; i++) begin
            set_cyc(3'b010);
            step();
            chk("tg_grant", 32'(grant), 32'b010);
            set_cyc('0);
            step();
            chk("tg_idle", 32'(grant), 0);
        end

        // A waiting master that gives up leaves no trace.
        set_cyc(3'b001);
        step();
        chk("dr_grant", 32'(grant), 32'b001);
        set_cyc(3'b011);
        step();
        set_cyc(3'b001);
        step();
        set_cyc('0);
        step();
        chk("dr_idle", 32'(grant), 0);
        step();
        chk("dr_none", 32'(grant), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
